// File: rtl/reaction_timer.sv
// Reaction timer: measures prescaled ticks from the "go" condition to the
// player's button press, flagging false starts and saturating overflow.
module reaction_timer #(
  parameter int COUNT_W  = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_arm,
  input  logic               i_go,
  input  logic               i_button,
  output logic [COUNT_W-1:0] o_result,
  output logic               o_valid,
  output logic               o_falseStart,
  output logic               o_overflow,
  output logic               o_busy
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TIMING = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r;
  logic                 button_q_r;
  logic [PRE_W-1:0]     prescaler_r;
  logic [COUNT_W-1:0]   count_r;
  logic [COUNT_W-1:0]   result_r;
  logic                 valid_r;
  logic                 false_start_r;
  logic                 overflow_r;

  logic                 press_s;
  logic                 tick_s;
  logic                 count_max_s;

  assign press_s     = i_button & ~button_q_r;
  assign tick_s      = (prescaler_r == PRE_LAST);
  assign count_max_s = &count_r;

  // Trial state machine with registered result and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      button_q_r    <= 1'b1;  // a button held through reset must not look like a press
      prescaler_r   <= {PRE_W{1'b0}};
      count_r       <= {COUNT_W{1'b0}};
      result_r      <= {COUNT_W{1'b0}};
      valid_r       <= 1'b0;
      false_start_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      button_q_r <= i_button;
      if (i_arm) begin
        state_r       <= ST_ARMED;
        prescaler_r   <= {PRE_W{1'b0}};
        count_r       <= {COUNT_W{1'b0}};
        result_r      <= {COUNT_W{1'b0}};
        valid_r       <= 1'b0;
        false_start_r <= 1'b0;
        overflow_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ARMED: begin
            if (press_s) begin
              state_r  <= ST_DONE;
              result_r <= {COUNT_W{1'b0}};
              if (i_go) begin
                valid_r <= 1'b1;
              end else begin
                false_start_r <= 1'b1;
              end
            end else if (i_go) begin
              state_r     <= ST_TIMING;
              prescaler_r <= {PRE_W{1'b0}};
              count_r     <= {COUNT_W{1'b0}};
            end else begin
              state_r <= ST_ARMED;
            end
          end
          ST_TIMING: begin
            // Press wins over a coincident tick: report the pre-tick count
            if (press_s) begin
              state_r  <= ST_DONE;
              valid_r  <= 1'b1;
              result_r <= count_r;
            end else if (tick_s) begin
              prescaler_r <= {PRE_W{1'b0}};
              if (count_max_s) begin
                state_r    <= ST_DONE;
                overflow_r <= 1'b1;
                result_r   <= {COUNT_W{1'b1}};
              end else begin
                count_r <= count_r + COUNT_W'(1);
              end
            end else begin
              prescaler_r <= prescaler_r + PRE_W'(1);
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_result     = result_r;
  assign o_valid      = valid_r;
  assign o_falseStart = false_start_r;
  assign o_overflow   = overflow_r;
  assign o_busy       = (state_r == ST_ARMED) || (state_r == ST_TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer (COUNT_W=8, TICK_DIV=4): expected trial
// outcomes are queued by the stimulus and checked by an independent monitor.
module tb_reaction_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       go = 1'b0;
  logic       button = 1'b0;
  logic [7:0] o_result;
  logic       o_valid;
  logic       o_falseStart;
  logic       o_overflow;
  logic       o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {valid, falseStart, overflow, result}
  logic [10:0] sb[$];

  reaction_timer #(.COUNT_W(8), .TICK_DIV(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_arm       (arm),
    .i_go        (go),
    .i_button    (button),
    .o_result    (o_result),
    .o_valid     (o_valid),
    .o_falseStart(o_falseStart),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {busy, valid, falseStart, overflow, result}
  function automatic logic [11:0] outs();
    return {o_busy, o_valid, o_falseStart, o_overflow, o_result};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no DONE outcome within %0d cycles, %0d pending, expected 0", name, n, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare each new DONE outcome against the scoreboard head
  initial begin
    logic done_prev;
    logic done_now;
    logic [10:0] exp;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      done_now = o_valid | o_falseStart | o_overflow;
      if (done_now && !done_prev) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got %h, expected no outcome",
                   {o_valid, o_falseStart, o_overflow, o_result});
        end else begin
          exp = sb.pop_front();
          if ({o_valid, o_falseStart, o_overflow, o_result} !== exp) begin
            n_fail++;
            $display("FAIL outcome: got %h, expected %h",
                     {o_valid, o_falseStart, o_overflow, o_result}, exp);
          end
        end
      end
      done_prev = done_now;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle behaviour
    cyc(2);
    check("reset_state", 12'h000);
    rst = 1'b0;
    button = 1'b1;
    go = 1'b1;
    cyc(3);
    check("idle_ignores_inputs", 12'h000);
    button = 1'b0;
    go = 1'b0;
    cyc(1);

    // 1: normal trial, press 22 cycles after go -> 5 ticks
    arm_pulse();
    check("armed_busy", 12'h800);
    cyc(4);
    go = 1'b1;
    cyc(22);
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd5});
    button = 1'b1;
    wait_sb("normal_trial");
    cyc(1);
    check("normal_done_held", 12'h405);

    // 2: false start, later go and presses ignored in DONE
    button = 1'b0;
    go = 1'b0;
    cyc(1);
    arm_pulse();
    cyc(2);
    sb.push_back({1'b0, 1'b1, 1'b0, 8'd0});
    button = 1'b1;
    wait_sb("false_start");
    cyc(1);
    go = 1'b1;
    button = 1'b0;
    cyc(3);
    button = 1'b1;
    cyc(2);
    check("false_start_held", 12'h200);

    // 3: go and press in the same cycle while armed
    button = 1'b0;
    go = 1'b0;
    cyc(1);
    arm_pulse();
    cyc(2);
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd0});
    go = 1'b1;
    button = 1'b1;
    wait_sb("simultaneous_go_press");
    cyc(1);
    check("simultaneous_held", 12'h400);

    // 6a: arm together with a press in DONE
    button = 1'b0;
    go = 1'b0;
    cyc(1);
    arm = 1'b1;
    button = 1'b1;
    cyc(1);
    arm = 1'b0;
    check("arm_over_press", 12'h800);
    cyc(3);
    check("arm_press_no_false_start", 12'h800);

    // 6c: press coinciding with a tick at count=3
    button = 1'b0;
    go = 1'b1;
    cyc(16);
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd3});
    button = 1'b1;
    wait_sb("press_on_tick");
    cyc(1);
    check("press_on_tick_held", 12'h403);

    // 4: overflow after the 256th tick, go dropped mid-trial
    button = 1'b0;
    go = 1'b0;
    cyc(1);
    arm_pulse();
    go = 1'b1;
    sb.push_back({1'b0, 1'b0, 1'b1, 8'hFF});
    cyc(4);
    go = 1'b0;
    cyc(1020);
    check("pre_overflow", 12'h800);
    cyc(1);
    check("overflow_flags", 12'h1FF);
    wait_sb("overflow");
    rst = 1'b1;
    cyc(1);
    check("reset_from_done", 12'h000);
    rst = 1'b0;
    cyc(1);

    // 6b: reset mid-TIMING
    arm_pulse();
    go = 1'b1;
    cyc(10);
    check("timing_busy", 12'h800);
    rst = 1'b1;
    cyc(1);
    check("reset_mid_timing", 12'h000);
    rst = 1'b0;
    go = 1'b0;
    cyc(1);

    // 5: button held through reset and arm, then release and press
    button = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    check("held_reset_state", 12'h000);
    arm_pulse();
    go = 1'b1;
    cyc(1);
    check("held_no_press", 12'h800);
    button = 1'b0;
    cyc(9);
    sb.push_back({1'b1, 1'b0, 1'b0, 8'd2});
    button = 1'b1;
    wait_sb("held_button");
    cyc(2);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
